// File: rtl/alu_pkg.sv
// Shared definitions for the execution-stage ALU and the ALU control decoder.
//   - Operation codes driven by ALU control into alu_multicycle.operation.
//   - Handshake FSM state encoding.
//   - Default operand width and shift-amount width (SHAMT_W = log2(WIDTH)).
package alu_pkg;

  localparam int unsigned WIDTH_DEF   = 64;
  localparam int unsigned SHAMT_W_DEF = 6;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_BLT = 4'b1110;
  localparam logic [3:0] OP_SLL = 4'b1111;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/sll_iter.sv
// Iterative one-bit-per-cycle left shifter used by alu_multicycle for SLL.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   start_i   load a_i into the shift register and shamt_i into the counter
//   a_i       value to shift
//   shamt_i   shift amount (must be non-zero when start_i is asserted)
//   value_o   shifted value that the current cycle's edge will produce
//   done_o    high in the last shift cycle; value_o is then the final result
import alu_pkg::*;

module sll_iter #(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   value_o,
  output logic               done_o
);

  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  // The counter idles at zero, so a loaded shift runs until it counts back down.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      sreg_d = a_i;
      cnt_d  = shamt_i;
    end else if (cnt_q != '0) begin
      sreg_d = sreg_q << 1;
      cnt_d  = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  // On the edge where the counter is 1 the final shift happens; expose that value.
  assign done_o  = (cnt_q == SHAMT_W'(1));
  assign value_o = sreg_q << 1;

endmodule

// File: rtl/alu_multicycle.sv
// Execution-stage ALU with valid/ready handshake. Single-cycle ops (AND, OR, ADD, SUB,
// BLT-compare, unknown) register result/zero on the accept edge. SLL uses the iterative
// shifter sll_iter and holds in_ready low while it runs.
// Optional feature macro: ALU_FAST_SHIFT_EN -- SLL uses a combinational barrel shifter,
// the SHIFT state and counter are not built, busy is tied 0 and in_ready tied 1.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   in_valid   operation and operands presented this cycle
//   in_ready   block can accept a new operation
//   operation  4-bit code from ALU control (see alu_pkg)
//   a, b       operands (b[SHAMT_W-1:0] is the shift amount for SLL)
//   result     registered result, held until the next completion
//   zero       registered branch flag, held with result
//   out_valid  one-cycle pulse when result/zero are updated
//   busy       high while an iterative shift is in progress
import alu_pkg::*;

module alu_multicycle #(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             busy
);

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_zero;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               out_valid_q, out_valid_d;

  assign shamt = b[SHAMT_W-1:0];

  // Single-cycle datapath.
  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b0;
    case (operation)
      OP_AND: begin
        alu_res  = a & b;
        alu_zero = (alu_res == '0);
      end
      OP_OR: begin
        alu_res  = a | b;
        alu_zero = (alu_res == '0);
      end
      OP_ADD: begin
        alu_res  = a + b;
        alu_zero = (alu_res == '0);
      end
      OP_SUB: begin
        alu_res  = a - b;
        alu_zero = (a == b);
      end
      OP_BLT: begin
        alu_zero = ($signed(a) < $signed(b));
        alu_res  = {{(WIDTH-1){1'b0}}, alu_zero};
      end
      OP_SLL: begin
`ifdef ALU_FAST_SHIFT_EN
        alu_res  = a << shamt;
`else
        // Only reached with shamt == 0; non-zero amounts go through sll_iter.
        alu_res  = a;
`endif
        alu_zero = (alu_res == '0);
      end
      default: begin
        alu_res  = '0;
        alu_zero = 1'b0;
      end
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN

  assign in_ready = 1'b1;
  assign busy     = 1'b0;

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = alu_res;
      zero_d      = alu_zero;
      out_valid_d = 1'b1;
    end
  end

`else

  state_e           state_q, state_d;
  logic             start_shift;
  logic             shift_done;
  logic [WIDTH-1:0] shift_value;

  sll_iter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_sll_iter (
    .clk_i   (clk),
    .rst_i   (reset),
    .start_i (start_shift),
    .a_i     (a),
    .shamt_i (shamt),
    .value_o (shift_value),
    .done_o  (shift_done)
  );

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == SHIFT);

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    start_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if ((operation == OP_SLL) && (shamt != '0)) begin
            start_shift = 1'b1;
            state_d     = SHIFT;
          end else begin
            result_d    = alu_res;
            zero_d      = alu_zero;
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (shift_done) begin
          result_d    = shift_value;
          zero_d      = (shift_value == '0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule
